// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs toward the controller and
// pipeline control outputs back to the datapath.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] if_id_rs_i;
    logic [REG_ADDR_W-1:0] if_id_rt_i;
    logic                  id_uses_rs_i;
    logic                  id_uses_rt_i;
    logic                  id_branch_i;
    logic [REG_ADDR_W-1:0] id_ex_rd_i;
    logic                  id_ex_regwrite_i;
    logic                  id_ex_memread_i;
    logic                  dmem_busy_i;
    logic                  branch_taken_i;
    logic                  cnt_clr_i;
    logic                  pc_write_o;
    logic                  if_id_write_o;
    logic                  bubble_o;
    logic                  if_id_flush_o;
    logic                  freeze_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output if_id_rs_i, if_id_rt_i, id_uses_rs_i, id_uses_rt_i, id_branch_i,
               id_ex_rd_i, id_ex_regwrite_i, id_ex_memread_i, dmem_busy_i,
               branch_taken_i, cnt_clr_i,
        input  pc_write_o, if_id_write_o, bubble_o, if_id_flush_o, freeze_o,
               stall_cnt_o
    );

    modport slave (
        input  if_id_rs_i, if_id_rt_i, id_uses_rs_i, id_uses_rt_i, id_branch_i,
               id_ex_rd_i, id_ex_regwrite_i, id_ex_memread_i, dmem_busy_i,
               branch_taken_i, cnt_clr_i,
        output pc_write_o, if_id_write_o, bubble_o, if_id_flush_o, freeze_o,
               stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle load-use and branch operand stalls,
// memory-busy freeze, taken-branch IF/ID flush and a saturating bubble counter.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 1,
    parameter int CNT_W      = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    hazard_ctrl_if.slave  hz
);
    localparam int REM_W = $clog2(MEM_LAT + 2);

    typedef enum logic {IDLE, STALL} state_e;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               matchRs;
    logic               matchRt;
    logic               match;
    logic               hazLoadUse;
    logic               hazBrAlu;
    logic               hazBrLoad;
    logic               hazard;
    logic [REM_W-1:0]   hazLen;
    logic               stall;
    logic               bubble;

    always_comb begin
        matchRs    = hz.id_uses_rs_i & (hz.if_id_rs_i == hz.id_ex_rd_i) & (hz.id_ex_rd_i != '0);
        matchRt    = hz.id_uses_rt_i & (hz.if_id_rt_i == hz.id_ex_rd_i) & (hz.id_ex_rd_i != '0);
        match      = matchRs | matchRt;
        hazLoadUse = hz.id_ex_memread_i & match;
        hazBrAlu   = hz.id_branch_i & hz.id_ex_regwrite_i & ~hz.id_ex_memread_i & match;
        hazBrLoad  = hz.id_branch_i & hz.id_ex_memread_i & match;
        hazard     = hazLoadUse | hazBrAlu | hazBrLoad;

        // A branch waiting on a load needs one extra cycle over plain load-use
        if (hazBrLoad) begin
            hazLen = REM_W'(MEM_LAT + 1);
        end else if (hazLoadUse) begin
            hazLen = REM_W'(MEM_LAT);
        end else begin
            hazLen = REM_W'(1);
        end

        stall  = (state_q == STALL) | ((state_q == IDLE) & hazard);
        bubble = stall & ~hz.dmem_busy_i;
    end

    always_comb begin
        hz.pc_write_o    = 1'b1;
        hz.if_id_write_o = 1'b1;
        hz.bubble_o      = 1'b0;
        hz.if_id_flush_o = 1'b0;
        hz.freeze_o      = 1'b0;
        if (rst_n_i) begin
            if (hz.dmem_busy_i) begin
                hz.freeze_o      = 1'b1;
                hz.pc_write_o    = 1'b0;
                hz.if_id_write_o = 1'b0;
            end else if (stall) begin
                hz.pc_write_o    = 1'b0;
                hz.if_id_write_o = 1'b0;
                hz.bubble_o      = 1'b1;
            end else begin
                hz.if_id_flush_o = hz.branch_taken_i;
            end
        end
    end

    assign hz.stall_cnt_o = cnt_q;

    // The detection cycle is already the first bubble, so STALL covers the remaining N-1
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        if (!hz.dmem_busy_i) begin
            case (state_q)
                IDLE: begin
                    if (hazard && (hazLen > REM_W'(1))) begin
                        state_d = STALL;
                        rem_d   = hazLen - REM_W'(1);
                    end
                end
                STALL: begin
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
            if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (hz.cnt_clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: two instances (MEM_LAT=2/CNT_W=16, MEM_LAT=3/CNT_W=4)
// share stimulus and are compared each cycle against a stall-length reference model.
module tb_hazard_ctrl;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic [RW-1:0] rs, rt, exRd;
    logic usesRs, usesRt, branch, regWrite, memRead, busy, taken, clr;

    hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(16)) busA ();
    hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(4))  busB ();

    hazard_ctrl #(.REG_ADDR_W(RW), .MEM_LAT(2), .CNT_W(16)) dutA (.clk_i(clk), .rst_n_i(rstN), .hz(busA));
    hazard_ctrl #(.REG_ADDR_W(RW), .MEM_LAT(3), .CNT_W(4))  dutB (.clk_i(clk), .rst_n_i(rstN), .hz(busB));

    assign busA.if_id_rs_i = rs;        assign busB.if_id_rs_i = rs;
    assign busA.if_id_rt_i = rt;        assign busB.if_id_rt_i = rt;
    assign busA.id_uses_rs_i = usesRs;  assign busB.id_uses_rs_i = usesRs;
    assign busA.id_uses_rt_i = usesRt;  assign busB.id_uses_rt_i = usesRt;
    assign busA.id_branch_i = branch;   assign busB.id_branch_i = branch;
    assign busA.id_ex_rd_i = exRd;      assign busB.id_ex_rd_i = exRd;
    assign busA.id_ex_regwrite_i = regWrite; assign busB.id_ex_regwrite_i = regWrite;
    assign busA.id_ex_memread_i = memRead;   assign busB.id_ex_memread_i = memRead;
    assign busA.dmem_busy_i = busy;     assign busB.dmem_busy_i = busy;
    assign busA.branch_taken_i = taken; assign busB.branch_taken_i = taken;
    assign busA.cnt_clr_i = clr;        assign busB.cnt_clr_i = clr;

    int total = 0;
    int bad = 0;

    int lat [2] = '{2, 3};
    longint cntMax [2] = '{65535, 15};
    int stallLeft [2] = '{0, 0};
    longint cntM [2] = '{0, 0};

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stall length demanded by the current ID/EX pair; 0 means no hazard
    function automatic int hazardLen(int k);
        bit m;
        m = exRd != 0 && ((usesRs && rs == exRd) || (usesRt && rt == exRd));
        if (!m) return 0;
        if (branch && memRead) return lat[k] + 1;
        if (memRead) return lat[k];
        if (branch && regWrite) return 1;
        return 0;
    endfunction

    task automatic checkCycle();
        logic [4:0] expOut;
        logic [4:0] got;
        longint gotCnt;
        for (int k = 0; k < 2; k++) begin
            if (!rstN) expOut = 5'b11000;
            else if (busy) expOut = 5'b00001;
            else if (stallLeft[k] > 0 || hazardLen(k) > 0) expOut = 5'b00100;
            else expOut = {3'b110, taken, 1'b0};
            if (k == 0) begin
                got = {busA.pc_write_o, busA.if_id_write_o, busA.bubble_o, busA.if_id_flush_o, busA.freeze_o};
                gotCnt = longint'(busA.stall_cnt_o);
            end else begin
                got = {busB.pc_write_o, busB.if_id_write_o, busB.bubble_o, busB.if_id_flush_o, busB.freeze_o};
                gotCnt = longint'(busB.stall_cnt_o);
            end
            checkOutput($sformatf("ctl%0d", k), longint'(got), longint'(expOut));
            checkOutput($sformatf("cnt%0d", k), gotCnt, cntM[k]);
        end
    endtask

    task automatic advanceModel();
        int n;
        bit isBubble;
        for (int k = 0; k < 2; k++) begin
            if (!busy) begin
                n = hazardLen(k);
                isBubble = stallLeft[k] > 0 || n > 0;
                if (stallLeft[k] > 0) stallLeft[k]--;
                else if (n > 0) stallLeft[k] = n - 1;
                if (isBubble && cntM[k] < cntMax[k]) cntM[k]++;
            end
            if (clr) cntM[k] = 0;
        end
    endtask

    task automatic setIdle();
        rs = '0; rt = '0; exRd = '0;
        usesRs = 0; usesRt = 0; branch = 0; regWrite = 0; memRead = 0;
        busy = 0; taken = 0; clr = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then model the rising edge
    task automatic applyStimulus(input logic [RW-1:0] iRs, input logic [RW-1:0] iRt,
                                 input logic iUsesRs, input logic iUsesRt, input logic iBranch,
                                 input logic [RW-1:0] iExRd, input logic iRegWrite, input logic iMemRead,
                                 input logic iBusy, input logic iTaken, input logic iClr);
        @(negedge clk);
        rs = iRs; rt = iRt; usesRs = iUsesRs; usesRt = iUsesRt; branch = iBranch;
        exRd = iExRd; regWrite = iRegWrite; memRead = iMemRead;
        busy = iBusy; taken = iTaken; clr = iClr;
        #1;
        checkCycle();
        advanceModel();
    endtask

    task automatic idleCycle(input logic iBusy, input logic iTaken);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, iBusy, iTaken, 0);
    endtask

    initial begin
        setIdle();
        rs = 5'd8; usesRs = 1; exRd = 5'd8; memRead = 1; regWrite = 1; busy = 1; taken = 1;
        #2;
        checkCycle();
        @(negedge clk);
        setIdle();
        rstN = 1'b1;

        // Load-use on r8
        applyStimulus(5'd8, 5'd0, 1, 0, 0, 5'd8, 1, 1, 0, 0, 0);
        idleCycle(0, 0); idleCycle(0, 0); idleCycle(0, 0);
        checkOutput("luCntA", longint'(busA.stall_cnt_o), 2);
        checkOutput("luCntB", longint'(busB.stall_cnt_o), 3);

        // Register 0 and unused operand never hazard
        applyStimulus(5'd0, 5'd0, 1, 1, 0, 5'd0, 1, 1, 0, 0, 0);
        applyStimulus(5'd8, 5'd0, 0, 0, 0, 5'd8, 1, 1, 0, 0, 0);
        idleCycle(0, 0);

        // Branch on r5 after ALU, then after load
        applyStimulus(5'd0, 5'd5, 0, 1, 1, 5'd5, 1, 0, 0, 0, 0);
        idleCycle(0, 0);
        applyStimulus(5'd0, 5'd5, 0, 1, 1, 5'd5, 1, 1, 0, 0, 0);
        repeat (4) idleCycle(0, 0);

        // Load-use with busy in second stall cycle
        applyStimulus(5'd8, 5'd0, 1, 0, 0, 5'd8, 1, 1, 0, 0, 0);
        idleCycle(1, 0); idleCycle(1, 0);
        repeat (3) idleCycle(0, 0);

        // Taken branch without and with an ALU hazard
        idleCycle(0, 1);
        applyStimulus(5'd0, 5'd5, 0, 1, 1, 5'd5, 1, 0, 0, 1, 0);
        applyStimulus(5'd0, 5'd5, 0, 1, 1, 5'd0, 0, 0, 0, 1, 0);
        idleCycle(0, 0);

        // Saturate the narrow counter, then clear
        repeat (7) begin
            applyStimulus(5'd8, 5'd0, 1, 0, 0, 5'd8, 1, 1, 0, 0, 0);
            idleCycle(0, 0); idleCycle(0, 0);
        end
        checkOutput("satB", longint'(busB.stall_cnt_o), 15);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idleCycle(0, 0);
        checkOutput("clrB", longint'(busB.stall_cnt_o), 0);

        // Asynchronous reset in the second stall cycle
        applyStimulus(5'd8, 5'd0, 1, 0, 0, 5'd8, 1, 1, 0, 0, 0);
        @(negedge clk);
        setIdle();
        #1;
        checkCycle();
        #1;
        rstN = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stallLeft[k] = 0;
            cntM[k] = 0;
        end
        #1;
        checkCycle();
        @(negedge clk);
        #1;
        checkCycle();
        rstN = 1'b1;
        applyStimulus(5'd8, 5'd0, 1, 0, 0, 5'd8, 1, 1, 0, 0, 0);
        repeat (4) idleCycle(0, 0);

        // Random traffic over a small register range to provoke matches
        for (int i = 0; i < 2500; i++) begin
            logic b, c;
            b = ($urandom_range(0, 99) < 15);
            c = !b && ($urandom_range(0, 99) < 3);
            applyStimulus(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 99) < 30), RW'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 40),
                          b, ($urandom_range(0, 99) < 20), c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core. It succeeds the single-cycle load-use detector in the ID stage. Adds multi-cycle load-use stalls for a MEM_LAT-cycle data memory, branch-in-ID operand hazards, whole-pipe freeze on data-memory busy, IF/ID flush on taken branch, and a saturating stall-cycle counter. Drives PC write enable, IF/ID write enable, the ID/EX bubble mux select and the IF/ID flush.

Parameters:
REG_ADDR_W, 5, register-specifier width
MEM_LAT, 1, data-memory load latency in cycles (>=1); load-use stall length
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
if_id_rs_i  input  REG_ADDR_W  rs of instruction in ID
if_id_rt_i  input  REG_ADDR_W  rt of instruction in ID
id_uses_rs_i  input  1  ID instruction reads rs
id_uses_rt_i  input  1  ID instruction reads rt
id_branch_i  input  1  ID instruction is a branch (compared in ID)
id_ex_rd_i  input  REG_ADDR_W  destination register of instruction in EX
id_ex_regwrite_i  input  1  EX instruction writes register file
id_ex_memread_i  input  1  EX instruction is a load
dmem_busy_i  input  1  data memory not ready; freeze entire pipe
branch_taken_i  input  1  branch in ID resolved taken this cycle
cnt_clr_i  input  1  synchronous clear of stall counter
pc_write_o  output  1  PC write enable
if_id_write_o  output  1  IF/ID register write enable
bubble_o  output  1  select zeroed control into ID/EX
if_id_flush_o  output  1  clear IF/ID to NOP
freeze_o  output  1  hold all pipeline registers
stall_cnt_o  output  CNT_W  bubble cycles inserted, saturating

Behaviour:
- match_x = id_uses_x_i & (if_id_x_i == id_ex_rd_i) & (id_ex_rd_i != 0), for x in {rs, rt}. match = match_rs | match_rt. Register 0 never hazards.
- Hazard classes, evaluated only in IDLE:
  - load-use: id_ex_memread_i & match. Length N = MEM_LAT.
  - branch-after-ALU: id_branch_i & id_ex_regwrite_i & !id_ex_memread_i & match. N = 1.
  - branch-after-load: id_branch_i & id_ex_memread_i & match. N = MEM_LAT+1. Takes precedence over plain load-use.
- States: IDLE, STALL. Register rem has width clog2(MEM_LAT+2).
- IDLE with hazard: stall is asserted combinationally in the detection cycle. If N>1, rem <= N-1 and next state is STALL; otherwise remain in IDLE.
- STALL: stall asserted unconditionally; hazard inputs ignored. rem decrements each cycle. When rem==1, next state is IDLE.
- Stall asserted: pc_write_o=0, if_id_write_o=0, bubble_o=1. Total stall length is exactly N consecutive cycles.
- dmem_busy_i=1 has highest priority:
  - freeze_o=1, pc_write_o=0, if_id_write_o=0, bubble_o=0, if_id_flush_o=0.
  - state, rem and counter are held; the stall resumes when busy drops.
- if_id_flush_o = branch_taken_i & !stall & !freeze. A stalled branch is not yet resolved, so no flush.
- No stall and no freeze: pc_write_o=1, if_id_write_o=1, bubble_o=0, freeze_o=0.
- stall_cnt_o: +1 on every clock with bubble_o=1, saturating at 2^CNT_W-1. cnt_clr_i takes priority over increment, giving 0 on the next edge.
- Reset (rst_n_i=0, asynchronous, including mid-stall):
  - state IDLE, rem 0, stall_cnt_o 0.
  - while reset is held, outputs are pc_write_o=1, if_id_write_o=1, bubble_o=0, if_id_flush_o=0, freeze_o=0.
  - first cycle after release evaluates hazards normally.

Test Plan:
- MEM_LAT=2, EX=lw r8, ID uses rs=r8 -> bubble_o=1 and pc_write_o=0 for exactly 2 cycles, then 1; stall_cnt_o=2.
- id_ex_rd_i=0 with load, ID rs=0; also match with id_uses_rs_i=0 -> no stall, pc_write_o=1 throughout.
- MEM_LAT=2, branch in ID on rt=r5:
  - EX=add r5 -> 1 stall cycle.
  - EX=lw r5 -> 3 stall cycles; stall_cnt_o increases by 3.
- MEM_LAT=3, load-use, dmem_busy_i=1 for 2 cycles in the 2nd stall cycle -> freeze_o=1, bubble_o=0 during busy; afterward 2 more stall cycles; total bubbles 3.
- branch_taken_i=1 with no hazard -> if_id_flush_o=1 for 1 cycle. Same with branch-after-ALU hazard -> flush 0 while stalled, 1 in the first unstalled cycle.
- CNT_W=4:
  - 20 bubble cycles -> stall_cnt_o holds 15.
  - cnt_clr_i pulse -> 0.
  - rst_n_i low in 2nd cycle of MEM_LAT=3 stall -> immediate pc_write_o=1, bubble_o=0; after release, IDLE.
